// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO: pointer wrap function
// and the grouped status-flag struct.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  // Wrap by explicit compare so non-power-of-two depths never touch unused slots.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    if (ptr == depth - 32'd1) begin
      return 32'd0;
    end else begin
      return ptr + 32'd1;
    end
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DATA_WIDTH register array with one write port and one read port
// that is registered (FWFT = 0) or combinational (FWFT = 1).
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = $clog2(DEPTH),
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [PTR_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [PTR_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  if (FWFT == 0) begin : g_reg_read
    logic [DATA_WIDTH-1:0] rdata_q;

    // Registered read port, cleared by reset so stale words never escape.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q <= {DATA_WIDTH{1'b0}};
      end else if (re) begin
        rdata_q <= mem_q[raddr];
      end else begin
        rdata_q <= rdata_q;
      end
    end

    assign rdata = rdata_q;
  end else begin : g_comb_read
    logic unused_s;
    assign unused_s = &{1'b0, re, rst_n};
    assign rdata    = mem_q[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO of any depth with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky error flags and optional FWFT.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = $clog2(DEPTH),
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int CW = PTR_WIDTH + 1;

  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo: AE_THRESH out of range 0..DEPTH-1");
  end
  if (AE_THRESH >= AF_THRESH) begin : g_bad_order
    $error("sync_fifo: AE_THRESH must be below AF_THRESH");
  end

  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_acc_s, rd_acc_s;
  logic [DATA_WIDTH-1:0] ram_rdata_s;
  fifo_status_t          status_s;

  // Flags decode straight from the registered count: no extra latency.
  assign status_s.full         = (count_q == CW'(DEPTH));
  assign status_s.empty        = (count_q == CW'(0));
  assign status_s.almost_full  = (count_q >= CW'(AF_THRESH));
  assign status_s.almost_empty = (count_q <= CW'(AE_THRESH));

  assign wr_acc_s = w_en & ~status_s.full;
  assign rd_acc_s = r_en & ~status_s.empty;

  // Next-state for pointers, occupancy, sticky errors and read-valid pulse.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_valid_d  = rd_acc_s;
    overflow_d  = (w_en & status_s.full)  | (overflow_q  & ~clr_err);
    underflow_d = (r_en & status_s.empty) | (underflow_q & ~clr_err);
    if (wr_acc_s) begin
      wr_ptr_d = PTR_WIDTH'(ptr_next(32'(wr_ptr_q), 32'(DEPTH)));
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_acc_s) begin
      rd_ptr_d = PTR_WIDTH'(ptr_next(32'(rd_ptr_q), 32'(DEPTH)));
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (wr_acc_s && !rd_acc_s) begin
      count_d = count_q + CW'(1);
    end else if (rd_acc_s && !wr_acc_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= {PTR_WIDTH{1'b0}};
      rd_ptr_q    <= {PTR_WIDTH{1'b0}};
      count_q     <= {CW{1'b0}};
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  sync_fifo_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .PTR_WIDTH  (PTR_WIDTH),
    .FWFT       (FWFT)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc_s),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .re    (rd_acc_s),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata_s)
  );

  // In fall-through mode the head word is masked while empty so stale
  // memory (e.g. after reset) never shows on data_out.
  if (FWFT != 0) begin : g_fwft_out
    logic unused_s;
    assign unused_s = rd_valid_q;
    assign data_out = status_s.empty ? {DATA_WIDTH{1'b0}} : ram_rdata_s;
    assign rd_valid = ~status_s.empty;
  end else begin : g_reg_out
    assign data_out = ram_rdata_s;
    assign rd_valid = rd_valid_q;
  end

  assign full         = status_s.full;
  assign empty        = status_s.empty;
  assign almost_full  = status_s.almost_full;
  assign almost_empty = status_s.almost_empty;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
